// File: rtl/div_issue_unit.sv
// Request-side front end for the signed M-extension divider: resolves RISC-V
// divide special cases locally, forwards ordinary operands and forms the REM result.
module div_issue_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_op_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      div_a_o,
    output logic [31:0]      div_b_o,
    output logic             div_in_valid_o,
    input  logic             div_in_ready_i,
    input  logic [31:0]      div_c_i,
    input  logic             div_out_valid_i,
    output logic             div_out_ready_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        REMC,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               op_q, op_d;
    logic [31:0]        div_a_q, div_a_d;
    logic [31:0]        div_b_q, div_b_d;
    logic               div_in_valid_q, div_in_valid_d;
    logic               div_out_ready_q, div_out_ready_d;
    logic [31:0]        quot_q, quot_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [31:0]        rem_prod;

    // The divider operand registers double as the latched a/b used by REMC.
    assign rem_prod = quot_q * div_b_q;

    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        op_d            = op_q;
        div_a_d         = div_a_q;
        div_b_d         = div_b_q;
        div_in_valid_d  = div_in_valid_q;
        div_out_ready_d = div_out_ready_q;
        quot_d          = quot_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_tag_d       = rsp_tag_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_i && req_ready_q) begin
                    req_ready_d = 1'b0;
                    op_d        = req_op_i;
                    rsp_tag_d   = req_tag_i;
                    div_a_d     = req_a_i;
                    div_b_d     = req_b_i;
                    if (req_b_i == '0) begin
                        rsp_data_d  = req_op_i ? req_a_i : '1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else if (req_a_i == 32'h8000_0000 && req_b_i == '1) begin
                        rsp_data_d  = req_op_i ? '0 : 32'h8000_0000;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        div_in_valid_d = 1'b1;
                        state_d        = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (div_in_valid_q && div_in_ready_i) begin
                    div_in_valid_d  = 1'b0;
                    div_out_ready_d = 1'b1;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (div_out_valid_i && div_out_ready_q) begin
                    quot_d          = div_c_i;
                    div_out_ready_d = 1'b0;
                    if (op_q) begin
                        state_d = REMC;
                    end else begin
                        rsp_data_d  = div_c_i;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            REMC: begin
                rsp_data_d  = div_a_q - rem_prod;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            op_q            <= 1'b0;
            div_a_q         <= '0;
            div_b_q         <= '0;
            div_in_valid_q  <= 1'b0;
            div_out_ready_q <= 1'b0;
            quot_q          <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_tag_q       <= '0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            op_q            <= op_d;
            div_a_q         <= div_a_d;
            div_b_q         <= div_b_d;
            div_in_valid_q  <= div_in_valid_d;
            div_out_ready_q <= div_out_ready_d;
            quot_q          <= quot_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_tag_q       <= rsp_tag_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign div_a_o         = div_a_q;
    assign div_b_o         = div_b_q;
    assign div_in_valid_o  = div_in_valid_q;
    assign div_out_ready_o = div_out_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_tag_o       = rsp_tag_q;

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit; the divider side is emulated by tasks
// that return hand-computed quotients.
module tb_div_issue_unit;

    logic        clock = 1'b0;
    logic        nreset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [4:0]  req_tag_i;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        div_in_valid_o;
    logic        div_in_ready_i;
    logic [31:0] div_c_i;
    logic        div_out_valid_i;
    logic        div_out_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_tag_o;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int in_valid_cycles = 0;

    always #5 clock = ~clock;

    div_issue_unit #(.TAG_W(5)) dut (
        .clock          (clock),
        .nreset         (nreset),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .req_tag_i      (req_tag_i),
        .div_a_o        (div_a_o),
        .div_b_o        (div_b_o),
        .div_in_valid_o (div_in_valid_o),
        .div_in_ready_i (div_in_ready_i),
        .div_c_i        (div_c_i),
        .div_out_valid_i(div_out_valid_i),
        .div_out_ready_o(div_out_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_tag_o      (rsp_tag_o)
    );

    always @(posedge clock) begin
        if (div_in_valid_o) in_valid_cycles++;
        if (div_in_valid_o && div_in_ready_i) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        int n;
        n = 0;
        @(negedge clock);
        while (req_ready_o !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_req timeout: req_ready_o=%b required 1", req_ready_o);
        end
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_tag_i   = tag;
        @(posedge clock);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic serve_div(input logic [31:0] quot, input int lat);
        int n;
        n = 0;
        while (div_in_valid_o !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL serve_div timeout: div_in_valid_o=%b required 1", div_in_valid_o);
            return;
        end
        div_in_ready_i = 1'b1;
        @(posedge clock);
        #1;
        div_in_ready_i = 1'b0;
        repeat (lat) @(negedge clock);
        div_out_valid_i = 1'b1;
        div_c_i         = quot;
        @(posedge clock);
        #1;
        div_out_valid_i = 1'b0;
        div_c_i         = '0;
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        #2;
        nreset = 1'b0;
        #1;
        tests++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || div_in_valid_o !== 1'b0 ||
            div_out_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b rsp_v=%b in_v=%b out_rdy=%b required 0000",
                     req_ready_o, rsp_valid_o, div_in_valid_o, div_out_ready_o);
        end
        tests++;
        if (rsp_data_o !== 32'h0 || rsp_tag_o !== 5'h0 || div_a_o !== 32'h0 || div_b_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: data=%h tag=%h a=%h b=%h required all 0",
                     rsp_data_o, rsp_tag_o, div_a_o, div_b_o);
        end
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        #1;
        tests++;
        if (req_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 0", req_ready_o);
        end
        @(negedge clock);
        tests++;
        if (req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready_o);
        end
    endtask

    task automatic test_basic_div();
        int hs0;
        hs0 = hs_cnt;
        send_req(1'b0, 32'd100, 32'd7, 5'd5);
        serve_div(32'd14, 3);
        @(negedge clock);
        tests++;
        if (rsp_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL div_latency: rsp_valid_o=%b required 1", rsp_valid_o);
        end
        tests++;
        if (rsp_data_o !== 32'd14) begin
            fails++;
            $display("FAIL div_data: got %h required %h", rsp_data_o, 32'd14);
        end
        tests++;
        if (rsp_tag_o !== 5'd5) begin
            fails++;
            $display("FAIL div_tag: got %0d required 5", rsp_tag_o);
        end
        tests++;
        if (hs_cnt - hs0 != 1) begin
            fails++;
            $display("FAIL div_handshakes: got %0d required 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_signed_rem();
        send_req(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9);
        serve_div(32'hFFFF_FFF2, 2);
        @(negedge clock);
        tests++;
        if (rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rem_remc_cycle: rsp_valid_o=%b required 0", rsp_valid_o);
        end
        @(negedge clock);
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL rem_data: valid=%b data=%h required 1/fffffffe", rsp_valid_o, rsp_data_o);
        end
        tests++;
        if (rsp_tag_o !== 5'd9) begin
            fails++;
            $display("FAIL rem_tag: got %0d required 9", rsp_tag_o);
        end
    endtask

    task automatic test_special(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_div, input logic [31:0] exp_rem);
        int iv0;
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            exp = (i == 0) ? exp_div : exp_rem;
            iv0 = in_valid_cycles;
            send_req(i[0], a, b, 5'(10 + i));
            @(negedge clock);
            tests++;
            if (rsp_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL special_latency op=%0d: rsp_valid_o=%b required 1", i, rsp_valid_o);
            end
            tests++;
            if (rsp_data_o !== exp || rsp_tag_o !== 5'(10 + i)) begin
                fails++;
                $display("FAIL special_data op=%0d: data=%h tag=%0d required %h/%0d",
                         i, rsp_data_o, rsp_tag_o, exp, 10 + i);
            end
            @(posedge clock);
            #1;
            tests++;
            if (in_valid_cycles != iv0 || div_out_ready_o !== 1'b0) begin
                fails++;
                $display("FAIL special_no_divider op=%0d: in_valid cycles=%0d out_rdy=%b required 0/0",
                         i, in_valid_cycles - iv0, div_out_ready_o);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic bad;
        bad = 1'b0;
        rsp_ready_i = 1'b0;
        send_req(1'b0, 32'd5, 32'd0, 5'd21);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hFFFF_FFFF || rsp_tag_o !== 5'd21 ||
                req_ready_o !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bp_hold: valid=%b data=%h tag=%0d ready=%b required 1/ffffffff/21/0",
                     rsp_valid_o, rsp_data_o, rsp_tag_o, req_ready_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clock);
        tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid_op();
        send_req(1'b0, 32'd1000, 32'd10, 5'd3);
        div_in_ready_i = 1'b1;
        @(posedge clock);
        #1;
        div_in_ready_i = 1'b0;
        @(negedge clock);
        tests++;
        if (div_out_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_wait_state: div_out_ready_o=%b required 1", div_out_ready_o);
        end
        nreset = 1'b0;
        #1;
        tests++;
        if (req_ready_o !== 1'b0 || div_out_ready_o !== 1'b0 || div_in_valid_o !== 1'b0 ||
            rsp_valid_o !== 1'b0 || div_a_o !== 32'h0 || div_b_o !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: ready=%b out_rdy=%b in_v=%b rsp_v=%b a=%h b=%h required zeros",
                     req_ready_o, div_out_ready_o, div_in_valid_o, rsp_valid_o, div_a_o, div_b_o);
        end
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        send_req(1'b0, 32'd9, 32'd3, 5'd7);
        serve_div(32'd3, 1);
        @(negedge clock);
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'd3 || rsp_tag_o !== 5'd7) begin
            fails++;
            $display("FAIL post_reset_div: valid=%b data=%h tag=%0d required 1/3/7",
                     rsp_valid_o, rsp_data_o, rsp_tag_o);
        end
    endtask

    initial begin
        req_valid_i     = 1'b0;
        req_op_i        = 1'b0;
        req_a_i         = '0;
        req_b_i         = '0;
        req_tag_i       = '0;
        div_in_ready_i  = 1'b0;
        div_c_i         = '0;
        div_out_valid_i = 1'b0;
        rsp_ready_i     = 1'b1;
        test_reset();
        test_basic_div();
        test_signed_rem();
        test_special(32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
        test_special(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        test_back_pressure();
        test_reset_mid_op();
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
